// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side handshake (req/data/ack/grant) and the UART TX
// launch interface (en/data/busy) plus the arbiter status strobes into one
// interface. Signal suffixes are written from the arbiter's point of view.
//
// Modports:
//   slave  - the arbiter itself: consumes requests and tx_busy_i, drives
//            ack/grant/launch/status outputs.
//   master - the environment (requesters + UART TX): drives requests, data
//            and busy, observes everything the arbiter produces.
//
// Signals:
//   req_i      [N_PORTS]              per-port request level
//   data_i     [N_PORTS*DATA_AMOUNT]  port k byte at [k*DATA_AMOUNT +: DATA_AMOUNT]
//   ack_o      [N_PORTS]              one-hot, one-cycle "byte latched" pulse
//   grant_id_o [$clog2(N_PORTS)]      owner of the current/last frame
//   tx_en_o                           one-cycle launch strobe to the UART TX
//   tx_data_o  [DATA_AMOUNT]          latched byte for the UART TX
//   tx_busy_i                         UART TX frame in progress
//   active_o                          arbiter is not idle
//   timeout_o                         one-cycle pulse when busy never arrived
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_PORTS     = 4,
  parameter int DATA_AMOUNT = 8
);

  localparam int ID_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0]             req_i;
  logic [N_PORTS*DATA_AMOUNT-1:0] data_i;
  logic [N_PORTS-1:0]             ack_o;
  logic [ID_W-1:0]                grant_id_o;
  logic                           tx_en_o;
  logic [DATA_AMOUNT-1:0]         tx_data_o;
  logic                           tx_busy_i;
  logic                           active_o;
  logic                           timeout_o;

  modport slave (
    input  req_i,
    input  data_i,
    input  tx_busy_i,
    output ack_o,
    output grant_id_o,
    output tx_en_o,
    output tx_data_o,
    output active_o,
    output timeout_o
  );

  modport master (
    output req_i,
    output data_i,
    output tx_busy_i,
    input  ack_o,
    input  grant_id_o,
    input  tx_en_o,
    input  tx_data_o,
    input  active_o,
    input  timeout_o
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter and launch sequencer sharing one UART transmitter among
// N_PORTS byte requesters. In IDLE it picks the next requesting port after the
// last winner, latches that port's byte, and issues a single-cycle launch
// together with the port's ack. It then waits for the transmitter to report
// busy (or gives up after BUSY_TIMEOUT cycles), waits for the frame to end,
// and inserts GAP_CYCLES idle cycles before the next selection.
//
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous, active-low reset
//   bus    - uart_tx_arbiter_if.slave (requests, launch interface, status)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int DATA_AMOUNT  = 8,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_tx_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_PORTS);
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [ID_W-1:0]    LAST_INIT = ID_W'(N_PORTS - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [16:0]        GAP_LEN   = 17'(GAP_CYCLES);
  localparam logic [N_PORTS-1:0] ONE_HOT0  = N_PORTS'(1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t                 state_q,    state_d;
  logic [N_PORTS-1:0]     ack_q,      ack_d;
  logic [ID_W-1:0]        grant_q,    grant_d;
  logic [ID_W-1:0]        last_q,     last_d;
  logic                   tx_en_q,    tx_en_d;
  logic [DATA_AMOUNT-1:0] tx_data_q,  tx_data_d;
  logic                   active_q,   active_d;
  logic                   timeout_q,  timeout_d;
  logic [TO_W-1:0]        to_cnt_q,   to_cnt_d;
  logic [15:0]            gap_cnt_q,  gap_cnt_d;

  logic                   sel_found;
  logic [ID_W-1:0]        sel_idx;
  logic [ID_W-1:0]        cand_idx;
  logic [DATA_AMOUNT-1:0] sel_data;
  logic [TO_W-1:0]        to_next;

  // Round-robin search: walk the ports starting one past the last winner and
  // wrapping around, taking the first one whose request is up. The last winner
  // itself is checked last, so a port that keeps requesting cannot starve the
  // others.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand_idx = ID_W'((int'(last_q) + k) % N_PORTS);
      if (!sel_found && bus.req_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Byte multiplexer for the winning port. Written as a constant-index loop so
  // every slice stays in range even when N_PORTS is not a power of two.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (sel_idx == ID_W'(k)) begin
        sel_data = bus.data_i[k*DATA_AMOUNT +: DATA_AMOUNT];
      end
    end
  end

  // Sequencer next-state logic. Launch and ack strobes are produced on the
  // transition out of IDLE so that, once registered, they are high exactly for
  // the single LAUNCH cycle. The timeout counter compares its incremented
  // value so the timeout pulse lands BUSY_TIMEOUT cycles after the launch
  // strobe. Both counters are cleared whenever their state is entered, so
  // neither can wrap. A GAP of zero cycles still spends one cycle in GAP.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    tx_en_d   = 1'b0;
    timeout_d = 1'b0;
    grant_d   = grant_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    to_next   = to_cnt_q + TO_W'(1);

    case (state_q)
      IDLE: begin
        if (sel_found && !bus.tx_busy_i) begin
          state_d   = LAUNCH;
          tx_en_d   = 1'b1;
          ack_d     = ONE_HOT0 << sel_idx;
          grant_d   = sel_idx;
          last_d    = sel_idx;
          tx_data_d = sel_data;
        end
      end

      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (bus.tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (to_next == TO_LAST) begin
          timeout_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_next;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy_i) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end

      GAP: begin
        if ((17'(gap_cnt_q) + 17'd1) >= GAP_LEN) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  // State and output registers. Reset clears everything immediately, which
  // also aborts any frame in progress without a further launch strobe, and
  // parks the round-robin pointer on the last port so port 0 wins first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      grant_q   <= '0;
      last_q    <= LAST_INIT;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.grant_id_o = grant_q;
  assign bus.tx_en_o    = tx_en_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.active_o   = active_q;
  assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with N_PORTS=4, DATA_AMOUNT=8,
// GAP_CYCLES=5, BUSY_TIMEOUT=16. The UART TX side is played by the main
// sequence, which raises and drops tx_busy_i by hand. Inputs change and
// outputs are sampled 1 time unit after each falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N_PORTS      = 4;
  localparam int DATA_AMOUNT  = 8;
  localparam int GAP_CYCLES   = 5;
  localparam int BUSY_TIMEOUT = 16;

  localparam logic [31:0] PORT_DATA = {8'hFF, 8'h7F, 8'h08, 8'h46};

  logic clk;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;
  int launches    = 0;
  int misaligned  = 0;
  int ack_count [N_PORTS];

  uart_tx_arbiter_if #(.N_PORTS(N_PORTS), .DATA_AMOUNT(DATA_AMOUNT)) bus ();

  uart_tx_arbiter #(
    .N_PORTS      (N_PORTS),
    .DATA_AMOUNT  (DATA_AMOUNT),
    .GAP_CYCLES   (GAP_CYCLES),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observer: counts launches and per-port acks, and flags any cycle where the
  // ack vector and the launch strobe disagree or ack is not one-hot.
  always @(negedge clk) begin
    if (bus.tx_en_o === 1'b1) launches++;
    if (((|bus.ack_o) !== bus.tx_en_o) || !$onehot0(bus.ack_o)) misaligned++;
    for (int k = 0; k < N_PORTS; k++) begin
      if (bus.ack_o[k] === 1'b1) ack_count[k]++;
    end
  end

  // Hard stop in case a wait somewhere never ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic applyStimulus(input logic [N_PORTS-1:0] req, input logic busy);
    bus.req_i     = req;
    bus.tx_busy_i = busy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] portByte(input int id);
    logic [31:0] d;
    d = PORT_DATA;
    return d[id*8 +: 8];
  endfunction

  // Steps until a launch strobe is seen or the budget runs out; the final
  // check records a missing launch as a failure.
  task automatic waitLaunch(input string tag, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (bus.tx_en_o !== 1'b1 && cycles < 60);
    checkOutput({tag, "_launch"}, 32'(bus.tx_en_o), 32'h1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    steps(2);
    rst_n = 1'b1;
  endtask

  // One frame with a cooperative transmitter: checks the launch, then busy
  // rises one cycle after the strobe and stays up for three cycles.
  task automatic runFrame(input string tag, input int exp_id);
    int cyc;
    waitLaunch(tag, cyc);
    checkOutput({tag, "_ack"},   32'(bus.ack_o),      32'(1) << exp_id);
    checkOutput({tag, "_grant"}, 32'(bus.grant_id_o), 32'(exp_id));
    checkOutput({tag, "_data"},  32'(bus.tx_data_o),  32'(portByte(exp_id)));
    step();
    bus.tx_busy_i = 1'b1;
    steps(3);
    bus.tx_busy_i = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int cyc;
    int saved;
    for (int k = 0; k < N_PORTS; k++) ack_count[k] = 0;
    bus.data_i = PORT_DATA;
    bus.req_i = '0;
    bus.tx_busy_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values.
    steps(2);
    checkOutput("rst_tx_en",   32'(bus.tx_en_o),    32'h0);
    checkOutput("rst_ack",     32'(bus.ack_o),      32'h0);
    checkOutput("rst_data",    32'(bus.tx_data_o),  32'h0);
    checkOutput("rst_grant",   32'(bus.grant_id_o), 32'h0);
    checkOutput("rst_active",  32'(bus.active_o),   32'h0);
    checkOutput("rst_timeout", 32'(bus.timeout_o),  32'h0);
    rst_n = 1'b1;

    // Single request from port 0: launch one cycle after the request edge.
    $display("[TB] single request");
    launches = 0;
    applyStimulus(4'b0001, 1'b0);
    step();
    checkOutput("single_tx_en",  32'(bus.tx_en_o),    32'h1);
    checkOutput("single_ack",    32'(bus.ack_o),      32'h1);
    checkOutput("single_data",   32'(bus.tx_data_o),  32'h46);
    checkOutput("single_grant",  32'(bus.grant_id_o), 32'h0);
    checkOutput("single_active", 32'(bus.active_o),   32'h1);
    applyStimulus(4'b0000, 1'b0);
    step();
    checkOutput("single_en_1cyc",  32'(bus.tx_en_o), 32'h0);
    checkOutput("single_ack_1cyc", 32'(bus.ack_o),   32'h0);
    step();
    applyStimulus(4'b0000, 1'b1);
    steps(20);
    applyStimulus(4'b0000, 1'b0);
    steps(5);
    checkOutput("single_gap_active", 32'(bus.active_o),  32'h1);
    checkOutput("single_data_hold",  32'(bus.tx_data_o), 32'h46);
    step();
    checkOutput("single_idle_active", 32'(bus.active_o), 32'h0);
    steps(10);
    checkOutput("single_launches", 32'(launches), 32'h1);

    // Fairness: all ports request continuously.
    $display("[TB] fairness");
    doReset();
    for (int k = 0; k < N_PORTS; k++) ack_count[k] = 0;
    applyStimulus(4'b1111, 1'b0);
    runFrame("rr0", 0);
    runFrame("rr1", 1);
    runFrame("rr2", 2);
    runFrame("rr3", 3);
    runFrame("rr4", 0);
    runFrame("rr5", 1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rr_acks_p0", 32'(ack_count[0]), 32'd2);
    checkOutput("rr_acks_p1", 32'(ack_count[1]), 32'd2);
    checkOutput("rr_acks_p2", 32'(ack_count[2]), 32'd1);
    checkOutput("rr_acks_p3", 32'(ack_count[3]), 32'd1);
    steps(20);

    // Gap: five GAP cycles and one IDLE cycle between busy falling and the
    // second launch.
    $display("[TB] gap");
    doReset();
    applyStimulus(4'b0011, 1'b0);
    waitLaunch("gap_first", cyc);
    checkOutput("gap_first_grant", 32'(bus.grant_id_o), 32'h0);
    applyStimulus(4'b0010, 1'b0);
    step();
    applyStimulus(4'b0010, 1'b1);
    steps(4);
    applyStimulus(4'b0010, 1'b0);
    steps(5);
    checkOutput("gap_last_active", 32'(bus.active_o), 32'h1);
    checkOutput("gap_no_early_en", 32'(bus.tx_en_o),  32'h0);
    step();
    checkOutput("gap_idle_active", 32'(bus.active_o), 32'h0);
    checkOutput("gap_idle_en",     32'(bus.tx_en_o),  32'h0);
    step();
    checkOutput("gap_second_en",    32'(bus.tx_en_o),    32'h1);
    checkOutput("gap_second_grant", 32'(bus.grant_id_o), 32'h1);
    checkOutput("gap_second_data",  32'(bus.tx_data_o),  32'h08);
    applyStimulus(4'b0000, 1'b0);
    steps(40);

    // Timeout: the transmitter never reports busy.
    $display("[TB] timeout");
    doReset();
    applyStimulus(4'b0101, 1'b0);
    waitLaunch("to_first", cyc);
    checkOutput("to_first_grant", 32'(bus.grant_id_o), 32'h0);
    applyStimulus(4'b0100, 1'b0);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.timeout_o !== 1'b1 && cyc < 40);
    checkOutput("to_delay", 32'(cyc), 32'd16);
    step();
    checkOutput("to_pulse_1cyc", 32'(bus.timeout_o), 32'h0);
    waitLaunch("to_next", cyc);
    checkOutput("to_next_delay", 32'(cyc), 32'd5);
    checkOutput("to_next_grant", 32'(bus.grant_id_o), 32'h2);
    checkOutput("to_next_data",  32'(bus.tx_data_o),  32'h7F);
    applyStimulus(4'b0000, 1'b0);
    steps(40);
    checkOutput("to_back_idle", 32'(bus.active_o), 32'h0);

    // Busy at idle: no selection while the transmitter is busy.
    $display("[TB] busy at idle");
    saved = launches;
    applyStimulus(4'b0100, 1'b1);
    steps(10);
    checkOutput("busyidle_no_launch", 32'(launches - saved), 32'h0);
    checkOutput("busyidle_no_ack",    32'(bus.ack_o),        32'h0);
    applyStimulus(4'b0100, 1'b0);
    step();
    checkOutput("busyidle_en",   32'(bus.tx_en_o),   32'h1);
    checkOutput("busyidle_ack",  32'(bus.ack_o),     32'h4);
    checkOutput("busyidle_data", 32'(bus.tx_data_o), 32'h7F);
    applyStimulus(4'b0000, 1'b0);
    steps(40);

    // Reset in the middle of a frame.
    $display("[TB] reset mid-frame");
    applyStimulus(4'b0001, 1'b0);
    waitLaunch("midrst_first", cyc);
    checkOutput("midrst_first_grant", 32'(bus.grant_id_o), 32'h0);
    applyStimulus(4'b0000, 1'b0);
    step();
    applyStimulus(4'b0000, 1'b1);
    steps(2);
    checkOutput("midrst_busy_active", 32'(bus.active_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_active", 32'(bus.active_o),   32'h0);
    checkOutput("midrst_data",   32'(bus.tx_data_o),  32'h0);
    checkOutput("midrst_grant",  32'(bus.grant_id_o), 32'h0);
    saved = launches;
    steps(2);
    checkOutput("midrst_no_launch", 32'(launches - saved), 32'h0);
    applyStimulus(4'b0101, 1'b0);
    rst_n = 1'b1;
    waitLaunch("midrst_after", cyc);
    checkOutput("midrst_after_delay", 32'(cyc),            32'd1);
    checkOutput("midrst_after_grant", 32'(bus.grant_id_o), 32'h0);
    checkOutput("midrst_after_data",  32'(bus.tx_data_o),  32'h46);
    applyStimulus(4'b0000, 1'b0);
    steps(5);

    checkOutput("ack_en_coincide", 32'(misaligned), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `N_PORTS` byte requesters (front-panel keys, loopback echo, status reporter). It sits between the requesters and the `en_i`/`data_i` launch interface of the UART TX, latches the winning byte, issues a single-cycle launch and holds off further launches until the transmitter has finished the frame plus a programmable inter-frame gap.

## Interface
- `N_PORTS`, 4: number of requesters, 2..8.
- `DATA_AMOUNT`, 8: data bits per frame.
- `GAP_CYCLES`, 0: idle clock cycles inserted after `tx_busy_i` falls before the next launch, 0..65535.
- `BUSY_TIMEOUT`, 16: cycles allowed between launch and `tx_busy_i` rising before the frame is abandoned, ≥2.

- `clk_i`  in  1  single system clock; all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `req_i`  in  N_PORTS  per-port request level; held high until that port's `ack_o` bit pulses.
- `data_i`  in  N_PORTS*DATA_AMOUNT  port k byte at bits [k*DATA_AMOUNT +: DATA_AMOUNT]; stable while `req_i[k]` high.
- `ack_o`  out  N_PORTS  one-hot, one-cycle pulse: port's byte latched.
- `grant_id_o`  out  $clog2(N_PORTS)  index of port owning the current/last frame.
- `tx_en_o`  out  1  one-cycle launch strobe to UART TX `en_i`.
- `tx_data_o`  out  DATA_AMOUNT  latched byte to UART TX `data_i`; stable from launch until return to IDLE.
- `tx_busy_i`  in  1  UART TX frame in progress.
- `active_o`  out  1  high in every state except IDLE.
- `timeout_o`  out  1  one-cycle pulse when `BUSY_TIMEOUT` expires.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if `|req_i` and `tx_busy_i`==0, select winner by round-robin, latch `data_i` slice into `tx_data_o`, set `grant_id_o`, go LAUNCH. If `tx_busy_i`==1, no selection.
- Round-robin: search starts at `last+1` modulo N_PORTS, wraps; `last` updates to winner at selection. After reset `last`=N_PORTS-1, so port 0 has highest priority first.
- LAUNCH (1 cycle): `tx_en_o`=1, `ack_o[winner]`=1; clear timeout counter; go WAIT_BUSY.
- WAIT_BUSY: `tx_busy_i`=1 → WAIT_DONE. Else counter increments; when counter reaches BUSY_TIMEOUT-1 without busy, pulse `timeout_o`, go GAP (byte is dropped, not retried; already acked).
- WAIT_DONE: `tx_busy_i` falls → GAP.
- GAP: counts GAP_CYCLES cycles then IDLE; with GAP_CYCLES=0, GAP lasts exactly 1 cycle.
- Requests dropped before selection are simply not served; requests asserted during a frame wait until IDLE.
- Timeout counter width $clog2(BUSY_TIMEOUT+1); gap counter 16 bits; neither wraps (cleared on state entry).

## Timing
- Reset (async assert, sync release): state IDLE, `ack_o`=0, `tx_en_o`=0, `tx_data_o`=0, `grant_id_o`=0, `active_o`=0, `timeout_o`=0, counters 0, `last`=N_PORTS-1. Reset mid-frame aborts with no further `tx_en_o`.
- Request-to-launch latency: `req_i` high at edge t (IDLE, not busy) → `tx_en_o` and `ack_o` high during cycle t+1.
- `ack_o` and `tx_en_o` always coincide, one cycle each, exactly once per frame.
- Back-to-back throughput: next `tx_en_o` earliest 1+GAP_CYCLES+1 cycles after `tx_busy_i` falls (GAP then IDLE selection).
- `tx_busy_i` high in LAUNCH cycle is ignored; only sampled from WAIT_BUSY on.

## Test plan
- Single request: reset, `req_i`=4'b0001, port0 byte 8'h46, TX model busy 2 cycles after `tx_en_o` for 100 cycles → one `tx_en_o`, `tx_data_o`=8'h46, `ack_o`=4'b0001 same cycle, `grant_id_o`=0, `active_o` low one cycle after GAP.
- Fairness: all four ports request continuously with 8'h46, 8'h08, 8'h7F, 8'hFF → launch order 0,1,2,3,0,1; each port acked once per four frames.
- Gap: GAP_CYCLES=5, two queued requests → exactly 5 GAP cycles plus 1 IDLE cycle between `tx_busy_i` fall and second `tx_en_o`.
- Timeout: TX model never asserts busy, BUSY_TIMEOUT=16 → `timeout_o` pulse 16 cycles after launch, FSM returns IDLE and serves next pending port.
- Busy at idle: `tx_busy_i` held high externally with `req_i`=4'b0100 → no `tx_en_o`/`ack_o` until busy drops, then launch with 8'h7F next cycle.
- Reset mid-frame: assert `rst_i`=0 in WAIT_DONE → all outputs 0 immediately; after release, port 0 wins first over simultaneous ports 0 and 2.
